// File: rtl/mem_access_arbiter.sv
// Arbitrates a single-ported backing memory between the fetch (IF) and memory-stage (DM) ports.
// One access at a time: one-cycle command strobe, wait for completion, one-cycle ready pulse.
module mem_access_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic               r_owner_dm, w_owner_dm;
  logic               r_wr, w_wr;
  logic [CNT_W-1:0]   r_starve, w_starve;
  logic               w_mem_enable, w_mem_write;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;
  logic               w_if_ready, w_dm_ready;
  logic [DATA_W-1:0]  w_if_rdata, w_dm_rdata;
  logic               w_dm_wins;

  // Stalls follow the requester's own handshake, independent of who owns the memory
  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner_dm <= 1'b0;
      r_wr       <= 1'b0;
      r_starve   <= '0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      r_state    <= w_state;
      r_owner_dm <= w_owner_dm;
      r_wr       <= w_wr;
      r_starve   <= w_starve;
      mem_enable <= w_mem_enable;
      mem_write  <= w_mem_write;
      mem_addr   <= w_mem_addr;
      mem_wdata  <= w_mem_wdata;
      if_ready   <= w_if_ready;
      dm_ready   <= w_dm_ready;
      if_rdata   <= w_if_rdata;
      dm_rdata   <= w_dm_rdata;
    end
  end

  // DM has priority unless IF has waited through STARVE_MAX consecutive DM grants
  assign w_dm_wins = dm_req && !(if_req && (r_starve == CNT_W'(STARVE_MAX)));

  always_comb begin
    w_state      = r_state;
    w_owner_dm   = r_owner_dm;
    w_wr         = r_wr;
    w_starve     = r_starve;
    w_mem_enable = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_addr   = mem_addr;
    w_mem_wdata  = mem_wdata;
    w_if_ready   = 1'b0;
    w_dm_ready   = 1'b0;
    w_if_rdata   = if_rdata;
    w_dm_rdata   = dm_rdata;
    case (r_state)
      S_IDLE: begin
        if (if_req || dm_req) begin
          w_state      = S_ISSUE;
          w_mem_enable = 1'b1;
          if (w_dm_wins) begin
            w_owner_dm  = 1'b1;
            w_wr        = dm_wr;
            w_mem_write = dm_wr;
            w_mem_addr  = dm_addr;
            w_mem_wdata = dm_wdata;
            if (!if_req) begin
              w_starve = '0;
            end else if (r_starve != CNT_W'(STARVE_MAX)) begin
              w_starve = r_starve + CNT_W'(1);
            end
          end else begin
            w_owner_dm  = 1'b0;
            w_wr        = 1'b0;
            w_mem_write = 1'b0;
            w_mem_addr  = if_addr;
            w_starve    = '0;
          end
        end else begin
          w_starve = '0;
        end
      end
      S_ISSUE: w_state = S_WAIT;
      S_WAIT: begin
        if (mem_done) begin
          w_state = S_RESP;
          if (r_owner_dm) begin
            w_dm_ready = 1'b1;
            if (!r_wr) begin
              w_dm_rdata = mem_rdata;
            end
          end else begin
            w_if_ready = 1'b1;
            w_if_rdata = mem_rdata;
          end
        end
      end
      S_RESP:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: a memory responder model, expected read data
// queued per port when requests are driven and compared when ready pulses.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_ready, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_enable, mem_write, mem_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned n_total = 0, n_pass = 0, n_fail = 0;
  logic [15:0] if_q[$];
  logic [15:0] dm_q[$];
  logic [32:0] cmd_log[$];
  logic [15:0] store [logic [15:0]];
  logic [15:0] exp_dm = 16'h0000;
  int unsigned mem_lat = 2;
  int unsigned if_ready_cnt = 0, dm_ready_cnt = 0;
  int unsigned rst_epoch = 0;
  logic        prev_en = 1'b0;
  logic        c_wr;
  logic [15:0] c_addr, c_wd;
  int unsigned c_epoch;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: logs each strobe and answers after mem_lat cycles
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst && mem_enable) begin
        cmd_log.push_back({mem_write, mem_addr, mem_wdata});
        c_wr = mem_write; c_addr = mem_addr; c_wd = mem_wdata; c_epoch = rst_epoch;
        repeat (mem_lat) @(negedge clk);
        if (c_epoch == rst_epoch) check("mem_addr_held", mem_addr, c_addr);
        if (c_wr) store[c_addr] = c_wd;
        mem_rdata = store.exists(c_addr) ? store[c_addr] : 16'hDEAD;
        mem_done  = 1'b1;
        @(negedge clk);
        mem_done  = 1'b0;
      end
    end
  end

  // Output monitor: stalls, strobe width, and ready pulses against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("if_stall", if_stall, if_req & ~if_ready);
        check("dm_stall", dm_stall, dm_req & ~dm_ready);
        if (mem_enable) check("strobe_width", prev_en, 1'b0);
        if (if_ready) begin
          if_ready_cnt++;
          if (if_q.size() == 0) check("if_unexpected_ready", 1'b1, 1'b0);
          else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (dm_ready) begin
          dm_ready_cnt++;
          if (dm_q.size() == 0) check("dm_unexpected_ready", 1'b1, 1'b0);
          else check("dm_rdata", dm_rdata, dm_q.pop_front());
        end
      end
      prev_en = mem_enable;
    end
  end

  task automatic wait_ready(input bit is_dm, output int unsigned lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (is_dm ? dm_ready : if_ready) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check(is_dm ? "dm_timeout" : "if_timeout", 1'b0, 1'b1);
  endtask

  task automatic if_read(input logic [15:0] addr, input logic [15:0] exp, output int unsigned lat);
    if_q.push_back(exp);
    if_addr = addr;
    if_req  = 1'b1;
    wait_ready(1'b0, lat);
    #1;
    if_req = 1'b0;
  endtask

  task automatic dm_acc(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] rd_exp, input bit last, output int unsigned lat);
    if (!wr) exp_dm = rd_exp;
    dm_q.push_back(exp_dm);
    dm_wr    = wr;
    dm_addr  = addr;
    dm_wdata = wdata;
    dm_req   = 1'b1;
    wait_ready(1'b1, lat);
    #1;
    if (last) begin
      dm_req = 1'b0;
      dm_wr  = 1'b0;
    end
  endtask

  task automatic chk_cmd(input int idx, input logic wr, input logic [15:0] addr);
    logic [32:0] c;
    if (idx >= cmd_log.size()) begin
      check("cmd_missing", 1'b0, 1'b1);
    end else begin
      c = cmd_log[idx];
      check("cmd_write", c[32], wr);
      check("cmd_addr", c[31:16], addr);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned lat_a, lat_b, cnt0;
    logic [32:0] c;
    store[16'h0010] = 16'hBEEF; store[16'h0000] = 16'h1111; store[16'h0002] = 16'h2222;
    store[16'h0004] = 16'h5A5A; store[16'h0040] = 16'h4040;
    for (int k = 0; k < 5; k++) store[16'h0100 + 16'(k)] = 16'hD000 + 16'(k);
    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {if_ready, dm_ready, mem_enable, mem_write, if_stall, dm_stall}, 6'b0);
    check("rst_data", {if_rdata, dm_rdata, mem_addr, mem_wdata}, 64'h0);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    // IF-only read: ready four cycles after the request is seen
    if_read(16'h0010, 16'hBEEF, lat_a);
    check("if_latency", lat_a, 4);
    check("cmd_count_t1", cmd_log.size(), 1);
    chk_cmd(0, 1'b0, 16'h0010);

    // DM read, then a write that must leave dm_rdata untouched, then read-back
    cmd_log.delete();
    dm_acc(1'b0, 16'h0004, 16'h0000, 16'h5A5A, 1'b1, lat_a);
    @(negedge clk); #1;
    dm_acc(1'b1, 16'h0200, 16'h1234, 16'h0000, 1'b1, lat_a);
    check("dm_wr_latency", lat_a, 4);
    check("dm_rdata_after_wr", dm_rdata, 16'h5A5A);
    chk_cmd(1, 1'b1, 16'h0200);
    if (cmd_log.size() > 1) begin
      c = cmd_log[1];
      check("cmd_wdata", c[15:0], 16'h1234);
    end
    @(negedge clk); #1;
    dm_acc(1'b0, 16'h0200, 16'h0000, 16'h1234, 1'b1, lat_a);

    // Simultaneous requests: DM first, IF follows
    @(negedge clk); #1;
    cmd_log.delete();
    fork
      if_read(16'h0010, 16'hBEEF, lat_b);
      dm_acc(1'b0, 16'h0002, 16'h0000, 16'h2222, 1'b1, lat_a);
    join
    check("sim_dm_latency", lat_a, 4);
    check("sim_if_latency", lat_b, 9);
    chk_cmd(0, 1'b0, 16'h0002);
    chk_cmd(1, 1'b0, 16'h0010);

    // Starvation: three DM grants, then IF, then DM resumes
    @(negedge clk); #1;
    cmd_log.delete();
    fork
      if_read(16'h0040, 16'h4040, lat_b);
      begin
        for (int k = 0; k < 5; k++)
          dm_acc(1'b0, 16'h0100 + 16'(k), 16'h0000, 16'hD000 + 16'(k), k == 4, lat_a);
      end
    join
    check("starve_cmd_count", cmd_log.size(), 6);
    chk_cmd(0, 1'b0, 16'h0100);
    chk_cmd(1, 1'b0, 16'h0101);
    chk_cmd(2, 1'b0, 16'h0102);
    chk_cmd(3, 1'b0, 16'h0040);
    chk_cmd(4, 1'b0, 16'h0103);
    chk_cmd(5, 1'b0, 16'h0104);

    // Back-to-back DM reads with request held across ready
    @(negedge clk); #1;
    cmd_log.delete();
    cnt0 = dm_ready_cnt;
    dm_acc(1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, lat_a);
    check("b2b_first_rdata", dm_rdata, 16'h1111);
    dm_acc(1'b0, 16'h0002, 16'h0000, 16'h2222, 1'b1, lat_b);
    check("b2b_second_latency", lat_b, 5);
    check("b2b_strobes", cmd_log.size(), 2);
    check("b2b_readies", dm_ready_cnt - cnt0, 2);
    chk_cmd(1, 1'b0, 16'h0002);

    // Reset during WAIT, stale completion afterwards must be dropped
    @(negedge clk); #1;
    cmd_log.delete();
    mem_lat = 4;
    dm_wr = 1'b0; dm_addr = 16'h0300; dm_req = 1'b1;
    lat_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_enable) begin
        lat_a = 1;
        break;
      end
    end
    check("rst_test_strobe_seen", lat_a, 1);
    @(negedge clk); #1;
    rst = 1'b0; dm_req = 1'b0; rst_epoch++; exp_dm = 16'h0000;
    #1;
    check("midrst_ctrl", {if_ready, dm_ready, mem_enable, mem_write}, 4'b0);
    check("midrst_data", {if_rdata, dm_rdata, mem_addr, mem_wdata}, 64'h0);
    @(negedge clk); #1;
    rst = 1'b1;
    cnt0 = dm_ready_cnt + if_ready_cnt;
    repeat (8) @(negedge clk);
    check("stale_no_ready", dm_ready_cnt + if_ready_cnt, cnt0);
    check("stale_no_strobe", cmd_log.size(), 1);
    #1;
    mem_lat = 2;
    if_read(16'h0010, 16'hBEEF, lat_a);
    check("post_rst_if_latency", lat_a, 4);
    check("queues_drained", if_q.size() + dm_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
